// File: rtl/forward_ctrl_unit.sv
// forward_ctrl_unit: EX-stage operand forwarding selects plus load-use stall detection.
// Tracks EX/MEM destination tags and registers 2-bit mux selects for the consumer's EX cycle.
module forward_ctrl_unit #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             ex_valid,
    output logic [CNT_W-1:0] stall_count
);
    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    logic             ex_v, ex_rw, ex_mr, mem_v, mem_rw;
    logic [REG_W-1:0] ex_rd, mem_rd;
    logic             ex_live, mem_live, ex_a, ex_b, mem_a, mem_b, bubble;
    logic [1:0]       sel_a, sel_b;

    // A tag only counts as a producer if it really writes a non-XZR register
    assign ex_live  = ex_v & ex_rw & (ex_rd != ZR);
    assign mem_live = mem_v & mem_rw & (mem_rd != ZR);
    assign ex_a     = ex_live & (ex_rd == id_rn);
    assign ex_b     = ex_live & (ex_rd == id_rm);
    assign mem_a    = mem_live & (mem_rd == id_rn);
    assign mem_b    = mem_live & (mem_rd == id_rm);

    assign stall    = id_valid & ~flush & ex_mr & (ex_a | ex_b);
    assign bubble   = flush | stall | ~id_valid;
    assign sel_a    = ex_a ? 2'b01 : mem_a ? 2'b10 : 2'b00;
    assign sel_b    = ex_b ? 2'b01 : mem_b ? 2'b10 : 2'b00;
    assign ex_valid = ex_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_v        <= 1'b0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            ex_rd       <= '0;
            mem_v       <= 1'b0;
            mem_rw      <= 1'b0;
            mem_rd      <= '0;
            fwdA        <= 2'b00;
            fwdB        <= 2'b00;
            stall_count <= '0;
        end else begin
            mem_v  <= ex_v;
            mem_rw <= ex_rw;
            mem_rd <= ex_rd;
            ex_v   <= ~bubble;
            ex_rw  <= id_regWrite;
            ex_mr  <= id_memRead;
            ex_rd  <= id_rd;
            fwdA   <= bubble ? 2'b00 : sel_a;
            fwdB   <= bubble ? 2'b00 : sel_b;
            if (stall && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule
